// File: rtl/a2d_spi_master.sv
`timescale 1ns/1ps
// a2d_spi_master: SPI master for the ADC128S 12-bit A2D converter.
// Two 16-bit frames per conversion; the second returns the result.
module a2d_spi_master #(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam int HALF = SCLK_DIV / 2;
  localparam int PW = $clog2(HALF);
  localparam int GW = $clog2(GAP_CLKS);
  localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);
  localparam logic [5:0] H_LAST = 6'd33;

  typedef enum logic [1:0] {
    IDLE, FRAME1, GAP, FRAME2
  } state_t;

  state_t        state_q;
  logic [PW-1:0] ph_q;
  logic [5:0]    hidx_q;
  logic [GW-1:0] gcnt_q;
  logic [4:0]    bcnt_q;
  logic [2:0]    ch_q;
  logic [15:0]   shreg_q;
  logic          smp_q;
  logic          ss_q;
  logic          sclk_q;
  logic          cmplt_q;
  logic [11:0]   res_q;

  logic [15:0] cmd_d;
  logic        in_frame_d;
  logic        half_end_d;
  logic        frame_end_d;
  logic [5:0]  hidx_d;
  logic        sclk_d;
  logic        rise_d;
  logic        shift_d;

  // A frame is 34 half-periods: porch, 16 low/high pairs, porch.
  always_comb begin
    cmd_d       = {2'b00, ch_q, 11'h000};
    in_frame_d  = (state_q == FRAME1) || (state_q == FRAME2);
    half_end_d  = in_frame_d && (ph_q == PH_LAST);
    frame_end_d = half_end_d && (hidx_q == H_LAST);
    hidx_d      = hidx_q + 6'd1;
    sclk_d      = !(hidx_d[0] && (hidx_d <= 6'd31));
    rise_d      = half_end_d && hidx_q[0] && (hidx_q <= 6'd31);
    shift_d     = half_end_d && !hidx_q[0] && (bcnt_q != 5'd0);
  end

  // Conversion sequencer, SCLK generator and shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      hidx_q  <= '0;
      gcnt_q  <= '0;
      bcnt_q  <= '0;
      ch_q    <= '0;
      shreg_q <= '0;
      smp_q   <= 1'b0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b1;
      cmplt_q <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (strt_cnv) begin
            state_q <= FRAME1;
            ss_q    <= 1'b0;
            cmplt_q <= 1'b0;
            ch_q    <= chnnl;
            shreg_q <= {2'b00, chnnl, 11'h000};
            ph_q    <= '0;
            hidx_q  <= '0;
            bcnt_q  <= '0;
          end
        end
        FRAME1, FRAME2: begin
          ph_q <= half_end_d ? '0 : ph_q + 1'b1;
          if (half_end_d) begin
            hidx_q <= hidx_d;
            sclk_q <= sclk_d;
          end
          if (rise_d) begin
            smp_q  <= MISO;
            bcnt_q <= bcnt_q + 5'd1;
          end
          if (shift_d) begin
            shreg_q <= {shreg_q[14:0], smp_q};
          end
          if (frame_end_d) begin
            ss_q   <= 1'b1;
            sclk_q <= 1'b1;
            hidx_q <= '0;
            bcnt_q <= '0;
            if (state_q == FRAME1) begin
              state_q <= GAP;
              gcnt_q  <= '0;
              shreg_q <= cmd_d;
            end else begin
              state_q <= IDLE;
              cmplt_q <= 1'b1;
              res_q   <= shreg_q[11:0];
              shreg_q <= '0;
            end
          end
        end
        GAP: begin
          if (gcnt_q == GAP_LAST) begin
            state_q <= FRAME2;
            ss_q    <= 1'b0;
            ph_q    <= '0;
            hidx_q  <= '0;
            bcnt_q  <= '0;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SS_n      = ss_q;
  assign SCLK      = sclk_q;
  assign MOSI      = shreg_q[15];
  assign cnv_cmplt = cmplt_q;
  assign res       = res_q;

endmodule

// File: tb/tb_a2d_spi_master.sv
`timescale 1ns/1ps
// tb_a2d_spi_master: ADC128S model plus scoreboard for two
// a2d_spi_master instances (default timing and a fast one).
module tb_a2d_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int val;
    int at;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] adc_val(input logic [2:0] c);
    case (c)
      3'd0:    return 12'h001;
      3'd1:    return 12'h123;
      3'd2:    return 12'hFFF;
      3'd3:    return 12'h357;
      3'd4:    return 12'h444;
      3'd5:    return 12'hABC;
      3'd6:    return 12'h666;
      default: return 12'h7E1;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no event, required one", nm);
  endtask

  for (genvar g = 0; g < 2; g++) begin : m
    localparam int DIV = (g == 0) ? 32 : 4;
    localparam int GP  = (g == 0) ? 32 : 2;
    localparam int HF  = DIV / 2;
    localparam int FL  = 17 * DIV;

    logic        strt = 1'b0;
    logic [2:0]  ch = 3'd0;
    logic        miso = 1'b0;
    logic        ss;
    logic        sclk;
    logic        mosi;
    logic        cmplt;
    logic [11:0] res;

    logic [15:0] rx = 16'h0;
    logic [2:0]  lch = 3'd0;
    int          nb = 15;
    logic [15:0] word;
    exp_t        rq[$];
    logic [15:0] wq[$];
    exp_t        e;
    int flen = 0, fp = 0, tl = 0, nf = 0;
    int gap = 0, fno = 0, bad = 0;
    logic pss = 1'b1, psclk = 1'b1, pcmp = 1'b0;

    a2d_spi_master #(
      .SCLK_DIV (DIV),
      .GAP_CLKS (GP)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strt_cnv  (strt),
      .chnnl     (ch),
      .cnv_cmplt (cmplt),
      .res       (res),
      .SS_n      (ss),
      .SCLK      (sclk),
      .MOSI      (mosi),
      .MISO      (miso)
    );

    assign word = {4'hA, adc_val(lch)};

    always @(posedge sclk) if (!ss) rx <= {rx[14:0], mosi};

    always @(posedge ss or negedge sclk)
      if (ss) begin
        nb  <= 15;
        lch <= rx[13:11];
      end else begin
        miso <= word[nb];
        nb   <= nb - 1;
      end

    always @(negedge clk) begin
      if (!rst_n) begin
        flen = 0; fp = 0; tl = 0; nf = 0; gap = 0; fno = 0;
        pss = 1'b1; psclk = 1'b1; pcmp = 1'b0;
      end else begin
        if (!ss) begin
          if (pss) begin
            if (fno % 2 == 1) chk($sformatf("m%0d_gap", g), gap, GP);
            flen = 0; fp = 0; tl = 0; nf = 0;
          end
          flen++;
          if (!sclk && psclk) nf++;
          if (sclk && nf == 0) fp++;
          tl = sclk ? tl + 1 : 0;
        end else begin
          if (!sclk) bad++;
          if (!pss) begin
            chk($sformatf("m%0d_frame_len", g), flen, FL);
            chk($sformatf("m%0d_front", g), fp, HF);
            chk($sformatf("m%0d_tail_high", g), tl, 2 * HF);
            chk($sformatf("m%0d_falls", g), nf, 16);
            if (wq.size() == 0) fail($sformatf("m%0d_word_expected", g));
            else chk($sformatf("m%0d_mosi_word", g), rx, wq.pop_front());
            fno++;
            gap = 0;
          end
          gap++;
        end
        if (cmplt && !pcmp) begin
          if (rq.size() == 0) fail($sformatf("m%0d_res_expected", g));
          else begin
            e = rq.pop_front();
            chk($sformatf("m%0d_res", g), res, e.val);
            chk($sformatf("m%0d_latency", g), cyc, e.at);
            chk($sformatf("m%0d_sclk_low_ss_high", g), bad, 0);
          end
        end
        pss = ss; psclk = sclk; pcmp = cmplt;
      end
    end
  end

  task automatic pulse(input int g, input logic [2:0] c,
                       input logic [15:0] w, input logic [11:0] v,
                       input bit acc, output int k);
    exp_t x;
    k = cyc + 1;
    x.val = v;
    x.at = k + ((g == 0) ? 1120 : 138);
    if (g == 0) begin
      m[0].strt = 1'b1;
      m[0].ch = c;
      if (acc) begin
        m[0].wq.push_back(w);
        m[0].wq.push_back(w);
        m[0].rq.push_back(x);
      end
    end else begin
      m[1].strt = 1'b1;
      m[1].ch = c;
      if (acc) begin
        m[1].wq.push_back(w);
        m[1].wq.push_back(w);
        m[1].rq.push_back(x);
      end
    end
    @(negedge clk);
    if (g == 0) m[0].strt = 1'b0;
    else m[1].strt = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    while (((g == 0) ? m[0].cmplt : m[1].cmplt) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail($sformatf("m%0d_done_timeout", g));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int k;
    int kx;
    repeat (3) @(negedge clk);
    chk("rst_ss", m[0].ss, 1);
    chk("rst_sclk", m[0].sclk, 1);
    chk("rst_mosi", m[0].mosi, 0);
    chk("rst_cmplt", m[0].cmplt, 0);
    chk("rst_res", m[0].res, 0);
    chk("rst_m1_ss", m[1].ss, 1);
    #2 rst_n = 1'b1;
    @(negedge clk);

    pulse(0, 3'd5, 16'h2800, 12'hABC, 1'b1, k);
    chk("ss_low_after_start", m[0].ss, 0);
    wait_done(0);

    @(negedge clk);
    pulse(0, 3'd7, 16'h3800, 12'h7E1, 1'b1, k);
    wait_cyc(k + 1119);
    pulse(0, 3'd1, 16'h0, 12'h0, 1'b0, kx);
    repeat (4) @(negedge clk);
    chk("strt_at_done_ignored", m[0].ss, 1);
    chk("cmplt_held", m[0].cmplt, 1);

    pulse(0, 3'd3, 16'h1800, 12'h357, 1'b1, k);
    wait_cyc(k + 9);
    pulse(0, 3'd6, 16'h0, 12'h0, 1'b0, kx);
    m[0].ch = 3'd4;
    wait_cyc(k + 599);
    pulse(0, 3'd6, 16'h0, 12'h0, 1'b0, kx);
    wait_done(0);

    @(negedge clk);
    pulse(0, 3'd0, 16'h0000, 12'h001, 1'b1, k);
    wait_done(0);
    pulse(0, 3'd2, 16'h1000, 12'hFFF, 1'b1, k);
    chk("cmplt_cleared", m[0].cmplt, 0);
    chk("res_hold_start", m[0].res, 12'h001);
    wait_cyc(k + 1100);
    chk("res_hold_late", m[0].res, 12'h001);
    wait_done(0);

    @(negedge clk);
    pulse(0, 3'd5, 16'h0, 12'h0, 1'b0, k);
    wait_cyc(k + 300);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ss", m[0].ss, 1);
    chk("midrst_sclk", m[0].sclk, 1);
    chk("midrst_cmplt", m[0].cmplt, 0);
    chk("midrst_res", m[0].res, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    pulse(0, 3'd5, 16'h2800, 12'hABC, 1'b1, k);
    wait_done(0);

    @(negedge clk);
    pulse(1, 3'd5, 16'h2800, 12'hABC, 1'b1, k);
    wait_done(1);
    @(negedge clk);
    pulse(1, 3'd2, 16'h1000, 12'hFFF, 1'b1, k);
    wait_done(1);

    repeat (5) @(negedge clk);
    chk("m0_pending", m[0].rq.size() + m[0].wq.size(), 0);
    chk("m1_pending", m[1].rq.size() + m[1].wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
